mmio_uart: RTL and testbench
============================

Name: mmio_uart

Overview:
- Memory-mapped UART peripheral on the core's data bus, downstream of the CPU top.
- Consumes mem_read/mem_write/mem_addr/mem_wdata/mem_wstrb and returns mem_rdata combinationally in the same cycle, because the core latches read data at the next clock edge.
- Contains an 8N1 transmitter fed by a TX FIFO, a single-byte RX holding register and a programmable baud divisor.
- Produces rdata=0 when not selected, so the SoC top can OR it with RAM read data.

Parameters:
BASE, 32'h1000_0000, base address of the 16-byte register window (aligned to 16).
TX_DEPTH, 8, TX FIFO entries (power of two, at least 2).
DIV_RESET, 16'd434, reset value of the baud divisor in clk cycles per bit.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset; one clock; all state cleared at posedge clk while high
mem_read  input  1  core read strobe
mem_write  input  1  core write strobe
mem_addr  input  32  byte address
mem_wdata  input  32  write data, already lane-shifted by the core
mem_wstrb  input  4  byte-lane write enables
mem_rdata  output  32  read data, combinational; 0 when not selected
sel  output  1  combinational; high when mem_addr[31:4]==BASE[31:4]
uart_tx  output  1  serial out, idle high
uart_rx  input  1  serial in, asynchronous

Behaviour:
- Register map, word offsets from mem_addr[3:2]:
  - 0 DATA: a write with wstrb[0] pushes wdata[7:0] into the TX FIFO. A read returns {24'b0,rx_byte} and, at the clock edge, clears rx_valid.
  - 1 STATUS, read-only: bit0 tx_full, bit1 tx_empty, bit2 tx_busy (FSM not IDLE), bit3 rx_valid, bit4 rx_overrun, bit5 tx_overflow, bit6 rx_frame_err. Reading STATUS clears bits 4-6 at the edge.
  - 2 DIV: read/write bits [15:0]; upper bits read 0. A write honours wstrb[1:0] per byte.
  - 3: reads 0, writes ignored.
- Side effects happen only when sel is high and mem_read or mem_write is high at the posedge.
- Reset values: uart_tx=1, FIFO empty, all status bits 0, rx_byte=0, DIV=DIV_RESET, TX and RX FSMs in IDLE.
- Effective bit period P = max(DIV,1) cycles.
- TX FIFO push:
  - Accepted when count<TX_DEPTH, or when the TX FSM pops in the same cycle.
  - Otherwise the byte is dropped and tx_overflow is set.
  - A set and a clear of tx_overflow in the same cycle: the set wins.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty, pop and move to START on the next edge.
  - Each state holds its line level for P cycles. START drives 0. DATA sends bits 0..7, LSB first. STOP drives 1.
  - After STOP, go directly to START if the FIFO is non-empty, with no idle gap; otherwise go to IDLE.
  - A frame is exactly 10P cycles.
  - A DIV write mid-frame takes effect at the next bit boundary.
- RX path: two-flop synchronizer; all decisions use the synchronized value.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: a falling edge moves to START.
  - START: after P/2 cycles, sample. If the sample is 1, it is a false start: return to IDLE. If 0, move to DATA.
  - DATA: sample 8 bits at P intervals.
  - STOP: sample after P. If 1, load rx_byte and set rx_valid; if rx_valid was already set, also set rx_overrun (the new byte overwrites). If 0, set rx_frame_err and discard the byte.
  - Return to IDLE in all cases.
  - A load of rx_valid and a DATA-read clear in the same cycle: the load wins.
- Reset asserted mid-frame: uart_tx is 1 from the next cycle and the FIFO contents are lost.
- Writes with wstrb=0, or to unselected addresses, have no effect.

Decomposition:
- Package mmio_pkg holds:
  - register offset localparams (REG_DATA, REG_STATUS, REG_DIV);
  - STATUS bit-index localparams;
  - the uart_state_e enum (IDLE, START, DATA, STOP), shared by both FSMs.
- Sub-module sync_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, full, empty, count) holds the TX FIFO.
- Both FSMs, the synchronizer and the register decode live in mmio_uart.

Test Plan:
- Reset, then read STATUS and DIV: rdata=32'h2 and 32'd434; uart_tx=1; an access at 32'h2000_0000 gives sel=0 and rdata=0.
- Write DIV=4, then DATA=8'hA5: uart_tx is low for 4 cycles, then 1,0,1,0,0,1,0,1 for 4 cycles each, then high for 4; tx_busy falls 40 cycles after the pop.
- Write 9 bytes back-to-back with DIV=4 while TX is idle: the first byte is popped, so all 9 fit, and the frames are contiguous with no idle gap. Write 10 more while the FIFO is full: tx_overflow=1, and it reads 0 after a STATUS read.
- Drive RX frame 8'h3C at P=8: rx_valid=1 and a DATA read returns 32'h3C with rx_valid cleared. Send a second frame without reading the first: rx_overrun=1 and rx_byte holds the new value.
- A 2-cycle low glitch on uart_rx at P=8 leaves rx_valid=0. A frame with stop bit 0 sets rx_frame_err=1 and leaves rx_byte unchanged.
- Assert rst for one cycle mid-TX-frame: uart_tx=1 and STATUS=32'h2 on the following cycle.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets, STATUS bit
// positions and the line-state encoding used by both serial FSMs.
package mmio_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;

  localparam int ST_TX_FULL   = 0;
  localparam int ST_TX_EMPTY  = 1;
  localparam int ST_TX_BUSY   = 2;
  localparam int ST_RX_VALID  = 3;
  localparam int ST_RX_OVR    = 4;
  localparam int ST_TX_OVF    = 5;
  localparam int ST_RX_FERR   = 6;
  localparam int STATUS_BITS  = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  // NOTE: storage is not reset; pointers and count define validity, so stale data is unreachable.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mmio_uart.sv
// Memory-mapped 8N1 UART: register decode, TX FSM fed by a FIFO, RX FSM with a
// two-flop synchronizer and single-byte holding register.
module mmio_uart #(
  parameter logic [31:0] BASE      = 32'h1000_0000,
  parameter int          TX_DEPTH  = 8,
  parameter logic [15:0] DIV_RESET = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        sel,
  output logic        uart_tx,
  input  logic        uart_rx
);

  import mmio_pkg::*;

  logic [1:0]  reg_off;
  logic        rd_en, wr_en;
  logic [15:0] div, p_eff, rx_half;
  logic        unused_bits;

  assign sel         = (mem_addr[31:4] == BASE[31:4]);
  assign reg_off     = mem_addr[3:2];
  assign rd_en       = sel && mem_read;
  assign wr_en       = sel && mem_write;
  assign p_eff       = (div == 16'd0) ? 16'd1 : div;
  assign rx_half     = (p_eff < 16'd2) ? 16'd1 : (p_eff >> 1);
  assign unused_bits = ^{mem_addr[1:0], mem_wdata[31:16], mem_wstrb[3:2]};

  // TX FIFO and transmitter
  logic                      fifo_full, fifo_empty, tx_pop, push_req;
  logic [7:0]                fifo_dout;
  logic [$clog2(TX_DEPTH):0] fifo_count;
  uart_state_e               tx_state;
  logic [15:0]               tx_cnt, tx_p;
  logic [7:0]                tx_shift;
  logic [2:0]                tx_bit;
  logic                      tx_tick;

  assign push_req = wr_en && (reg_off == REG_DATA) && mem_wstrb[0];
  assign tx_tick  = (tx_cnt >= tx_p - 16'd1);
  assign tx_pop   = !fifo_empty && ((tx_state == IDLE) || ((tx_state == STOP) && tx_tick));

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (tx_pop),
    .din   (mem_wdata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Bit period is latched at each bit boundary so a DIV write never stretches the current bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_p     <= 16'd1;
      tx_shift <= '0;
      tx_bit   <= '0;
    end else if (tx_state == IDLE) begin
      if (tx_pop) begin
        tx_state <= START;
        tx_shift <= fifo_dout;
        tx_cnt   <= '0;
        tx_p     <= p_eff;
      end
    end else if (tx_tick) begin
      tx_cnt <= '0;
      tx_p   <= p_eff;
      case (tx_state)
        START: begin
          tx_state <= DATA;
          tx_bit   <= '0;
        end
        DATA: begin
          if (tx_bit == 3'd7) tx_state <= STOP;
          else begin
            tx_bit   <= tx_bit + 3'd1;
            tx_shift <= tx_shift >> 1;
          end
        end
        default: begin
          if (tx_pop) begin
            tx_state <= START;
            tx_shift <= fifo_dout;
          end else begin
            tx_state <= IDLE;
          end
        end
      endcase
    end else begin
      tx_cnt <= tx_cnt + 16'd1;
    end
  end

  assign uart_tx = (tx_state == START) ? 1'b0 :
                   (tx_state == DATA)  ? tx_shift[0] : 1'b1;

  // Receiver
  logic        rx_s1, rx_s2, rx_prev;
  uart_state_e rx_state;
  logic [15:0] rx_cnt;
  logic [7:0]  rx_shift;
  logic [2:0]  rx_bit;
  logic        rx_stop_tick, rx_load, rx_ferr_set;

  assign rx_stop_tick = (rx_state == STOP) && (rx_cnt >= p_eff - 16'd1);
  assign rx_load      = rx_stop_tick && rx_s2;
  assign rx_ferr_set  = rx_stop_tick && !rx_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= IDLE;
      rx_cnt   <= '0;
      rx_shift <= '0;
      rx_bit   <= '0;
    end else begin
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      case (rx_state)
        IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_state <= START;
            rx_cnt   <= '0;
          end
        end
        START: begin
          if (rx_cnt >= rx_half - 16'd1) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s2 ? IDLE : DATA;
          end else rx_cnt <= rx_cnt + 16'd1;
        end
        DATA: begin
          if (rx_cnt >= p_eff - 16'd1) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else rx_cnt <= rx_cnt + 16'd1;
        end
        default: begin
          if (rx_stop_tick) rx_state <= IDLE;
          else              rx_cnt   <= rx_cnt + 16'd1;
        end
      endcase
    end
  end

  // Registers and sticky status; a set always wins over a clear in the same cycle.
  logic [7:0] rx_byte;
  logic       rx_valid, rx_overrun, tx_overflow, rx_frame_err, stat_clr;

  assign stat_clr = rd_en && (reg_off == REG_STATUS);

  always_ff @(posedge clk) begin
    if (rst) begin
      div          <= DIV_RESET;
      rx_byte      <= '0;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      tx_overflow  <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      if (wr_en && (reg_off == REG_DIV)) begin
        if (mem_wstrb[0]) div[7:0]  <= mem_wdata[7:0];
        if (mem_wstrb[1]) div[15:8] <= mem_wdata[15:8];
      end
      if (rx_load) rx_byte <= rx_shift;

      if (rx_load)                                rx_valid <= 1'b1;
      else if (rd_en && (reg_off == REG_DATA))    rx_valid <= 1'b0;

      if (rx_load && rx_valid)                    rx_overrun <= 1'b1;
      else if (stat_clr)                          rx_overrun <= 1'b0;

      if (push_req && fifo_full && !tx_pop)       tx_overflow <= 1'b1;
      else if (stat_clr)                          tx_overflow <= 1'b0;

      if (rx_ferr_set)                            rx_frame_err <= 1'b1;
      else if (stat_clr)                          rx_frame_err <= 1'b0;
    end
  end

  logic [STATUS_BITS-1:0] status;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    status               = '0;
    status[ST_TX_FULL]   = fifo_full;
    status[ST_TX_EMPTY]  = (fifo_count == '0);
    status[ST_TX_BUSY]   = (tx_state != IDLE);
    status[ST_RX_VALID]  = rx_valid;
    status[ST_RX_OVR]    = rx_overrun;
    status[ST_TX_OVF]    = tx_overflow;
    status[ST_RX_FERR]   = rx_frame_err;
  end

  always_comb begin
    mem_rdata = '0;
    if (sel) begin
      case (reg_off)
        REG_DATA:   mem_rdata = {24'b0, rx_byte};
        REG_STATUS: mem_rdata = {{(32-STATUS_BITS){1'b0}}, status};
        REG_DIV:    mem_rdata = {16'b0, div};
        default:    mem_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart.sv
// Directed bench for mmio_uart: register access, TX framing and FIFO overflow,
// RX receive/overrun/glitch/framing error and mid-frame reset.
module tb_mmio_uart;

  localparam logic [31:0] A_DATA = 32'h1000_0000;
  localparam logic [31:0] A_STAT = 32'h1000_0004;
  localparam logic [31:0] A_DIV  = 32'h1000_0008;
  localparam logic [31:0] A_R3   = 32'h1000_000C;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        sel, uart_tx, uart_rx;

  int checks = 0;
  int errors = 0;

  logic [7:0]  tx_bytes [9];
  logic [31:0] d;

  always #5 clk = ~clk;

  mmio_uart dut (
    .clk       (clk),
    .rst       (rst),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .sel       (sel),
    .uart_tx   (uart_tx),
    .uart_rx   (uart_rx)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    mem_addr  = addr;
    mem_wdata = data;
    mem_wstrb = strb;
    mem_write = 1'b1;
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    mem_wstrb = 4'h0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    mem_addr = addr;
    mem_read = 1'b1;
    #1;
    data = mem_rdata;
    @(posedge clk);
    #1;
    mem_read = 1'b0;
  endtask

  // Look at read data without a strobe, so no read side effect occurs.
  task automatic peek(input logic [31:0] addr, output logic [31:0] data);
    mem_addr = addr;
    #1;
    data = mem_rdata;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    idle(8);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      idle(8);
    end
    uart_rx = stop_bit;
    idle(8);
    uart_rx = 1'b1;
    idle(8);
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int pos);
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return b[pos-1];
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    mem_addr = A_STAT; mem_wdata = '0; mem_wstrb = '0; uart_rx = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);

    // Reset state and decode
    peek(A_STAT, d); check("rst_status", d, 32'h2);
    peek(A_DIV, d);  check("rst_div", d, 32'd434);
    check("rst_tx", {31'b0, uart_tx}, 32'd1);
    peek(A_R3, d);   check("reg3_zero", d, 32'h0);
    mem_addr = 32'h2000_0000; mem_read = 1'b1; #1;
    check("unsel_sel", {31'b0, sel}, 32'd0);
    check("unsel_rdata", mem_rdata, 32'h0);
    mem_read = 1'b0;
    idle(1);

    // DIV byte strobes, upper bits read zero
    bus_write(A_DIV, 32'hABCD_1234, 4'b0001);
    peek(A_DIV, d); check("div_lane0", d, 32'h0000_0134);
    bus_write(A_DIV, 32'hFFFF_0004, 4'b1111);
    peek(A_DIV, d); check("div_full", d, 32'h0000_0004);

    // Writes that must not push
    bus_write(A_DATA, 32'h55, 4'b0000);
    peek(A_STAT, d); check("wstrb0_nopush", d, 32'h2);
    bus_write(32'h2000_0000, 32'h55, 4'b0001);
    peek(A_STAT, d); check("unsel_nopush", d, 32'h2);

    // Single frame 0xA5 at P=4
    bus_write(A_DATA, 32'hA5, 4'b0001);
    idle(1);
    for (int c = 0; c < 40; c++) begin
      check($sformatf("a5_bit%0d", c), {31'b0, uart_tx}, {31'b0, frame_bit(8'hA5, c / 4)});
      if (c == 39) begin
        peek(A_STAT, d); check("a5_busy_last", {31'b0, d[2]}, 32'd1);
      end
      idle(1);
    end
    peek(A_STAT, d); check("a5_busy_fall", d, 32'h2);
    check("a5_tx_idle", {31'b0, uart_tx}, 32'd1);

    // Nine back-to-back bytes, contiguous frames, then overflow
    for (int k = 0; k < 9; k++) tx_bytes[k] = 8'h30 + 8'(k * 19);
    bus_write(A_DATA, {24'b0, tx_bytes[0]}, 4'b0001);
    fork
      begin
        idle(1);
        for (int c = 0; c < 360; c++) begin
          check($sformatf("burst_bit%0d", c), {31'b0, uart_tx},
                {31'b0, frame_bit(tx_bytes[c / 40], (c % 40) / 4)});
          idle(1);
        end
      end
      begin
        logic [31:0] r;
        for (int k = 1; k < 9; k++) bus_write(A_DATA, {24'b0, tx_bytes[k]}, 4'b0001);
        peek(A_STAT, r); check("fifo_full", r, 32'h05);
        for (int k = 0; k < 10; k++) bus_write(A_DATA, 32'hEE, 4'b0001);
        peek(A_STAT, r); check("ovf_peek", r, 32'h25);
        bus_read(A_STAT, r); check("ovf_read", r, 32'h25);
        peek(A_STAT, r); check("ovf_cleared", r, 32'h05);
      end
    join
    peek(A_STAT, d); check("burst_done", d, 32'h2);
    check("burst_tx_idle", {31'b0, uart_tx}, 32'd1);

    // Receive path at P=8
    bus_write(A_DIV, 32'h8, 4'b0011);
    send_rx(8'h3C, 1'b1);
    peek(A_STAT, d); check("rx_valid", d, 32'h0A);
    bus_read(A_DATA, d); check("rx_data", d, 32'h3C);
    peek(A_STAT, d); check("rx_valid_clr", d, 32'h02);
    send_rx(8'h3C, 1'b1);
    send_rx(8'h5A, 1'b1);
    peek(A_STAT, d); check("rx_overrun", d, 32'h1A);
    peek(A_DATA, d); check("rx_overwrite", d, 32'h5A);
    bus_read(A_STAT, d); check("ovr_read", d, 32'h1A);
    peek(A_STAT, d); check("ovr_cleared", d, 32'h0A);
    bus_read(A_DATA, d); check("rx_data2", d, 32'h5A);

    uart_rx = 1'b0;
    idle(2);
    uart_rx = 1'b1;
    idle(20);
    peek(A_STAT, d); check("glitch_ignored", d, 32'h02);

    send_rx(8'h77, 1'b0);
    peek(A_STAT, d); check("frame_err", d, 32'h42);
    peek(A_DATA, d); check("ferr_keeps_byte", d, 32'h5A);
    bus_read(A_STAT, d);
    peek(A_STAT, d); check("ferr_cleared", d, 32'h02);

    // Reset in the middle of a frame with a byte still queued
    bus_write(A_DATA, 32'h00, 4'b0001);
    bus_write(A_DATA, 32'h00, 4'b0001);
    idle(20);
    check("mid_frame_low", {31'b0, uart_tx}, 32'd0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("rst_mid_tx", {31'b0, uart_tx}, 32'd1);
    peek(A_STAT, d); check("rst_mid_status", d, 32'h2);
    peek(A_DIV, d);  check("rst_mid_div", d, 32'd434);
    idle(3);
    check("rst_tx_stays", {31'b0, uart_tx}, 32'd1);
    peek(A_STAT, d); check("rst_fifo_lost", d, 32'h2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
